// File: rtl/pdm_audio_pkg.sv
// ---------------------------------------------------------------------------
// pdm_audio_pkg
// Shared definitions for the PDM audio path (capture sequencer and pdm_filter).
//   - default timing/width parameters shared with pdm_filter
//   - capture FSM state encoding
//   - lg2(): number of bits needed to hold a value
// ---------------------------------------------------------------------------
package pdm_audio_pkg;

    localparam int unsigned SAMPLE_CLKS_DEF   = 375;
    localparam int unsigned SAMPLEHS_CLKS_DEF = 15;
    localparam int unsigned BITS_DEF          = 18;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StWake   = 2'd1,
        StSettle = 2'd2,
        StRun    = 2'd3
    } state_e;

    // Bits needed to represent the value x (minimum 1), e.g. lg2(14) = 4.
    function automatic int unsigned lg2(input int unsigned x);
        int unsigned n;
        n = 1;
        while ((n < 32) && ((x >> n) != 0)) begin
            n = n + 1;
        end
        return n;
    endfunction

endpackage

// File: rtl/pdm_capture_ctrl_if.sv
// ---------------------------------------------------------------------------
// pdm_capture_ctrl_if
// Bus-side handshake between the capture sequencer and the register block.
// Signal names are from the capture sequencer's point of view.
//   o_data          held decimated sample
//   o_data_valid    o_data not yet consumed
//   o_overrun       sticky: a sample was overwritten before being consumed
//   i_data_ack      bus side consumed o_data
//   i_clear_overrun clears o_overrun
// Modports: master = capture sequencer, slave = register block.
// ---------------------------------------------------------------------------
interface pdm_capture_ctrl_if
    import pdm_audio_pkg::*;
#(
    parameter int unsigned BITS = BITS_DEF
);
    logic [BITS-1:0] o_data;
    logic            o_data_valid;
    logic            o_overrun;
    logic            i_data_ack;
    logic            i_clear_overrun;

    modport master (
        output o_data,
        output o_data_valid,
        output o_overrun,
        input  i_data_ack,
        input  i_clear_overrun
    );

    modport slave (
        input  o_data,
        input  o_data_valid,
        input  o_overrun,
        output i_data_ack,
        output i_clear_overrun
    );
endinterface

// File: rtl/pdm_window_counter.sv
// ---------------------------------------------------------------------------
// pdm_window_counter
// Synchronizes the raw PDM bit and counts ones over each high-speed window.
// Ports:
//   i_clk, i_reset    clock, synchronous active-high reset
//   i_clear           holds window and ones counters at 0, suppresses strobe
//   i_pdm_data        asynchronous PDM pin bit
//   o_sample          ones count of the last completed window
//   o_sample_ready    one-cycle strobe when o_sample is updated
// ---------------------------------------------------------------------------
module pdm_window_counter
    import pdm_audio_pkg::*;
#(
    parameter int unsigned SAMPLEHS_CLKS = SAMPLEHS_CLKS_DEF,
    localparam int unsigned CW           = lg2(SAMPLEHS_CLKS - 1)
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_clear,
    input  logic          i_pdm_data,
    output logic [CW-1:0] o_sample,
    output logic          o_sample_ready
);
    localparam logic [CW-1:0] LAST_WCNT = CW'(SAMPLEHS_CLKS - 1);

    logic          r_sync1;
    logic          r_sync2;
    logic [CW-1:0] r_wcnt;
    logic [CW-1:0] r_ones;
    logic [CW-1:0] r_sample;
    logic          r_sample_ready;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_sync1        <= 1'b0;
            r_sync2        <= 1'b0;
            r_wcnt         <= '0;
            r_ones         <= '0;
            r_sample       <= '0;
            r_sample_ready <= 1'b0;
        end else begin
            r_sync1 <= i_pdm_data;
            r_sync2 <= r_sync1;
            if (i_clear) begin
                r_wcnt         <= '0;
                r_ones         <= '0;
                r_sample_ready <= 1'b0;
            end else if (r_wcnt == LAST_WCNT) begin
                // Last slot of the window samples no bit: SAMPLEHS_CLKS-1 bits
                // per window keeps the count centred on SAMPLEHS_CLKS>>1.
                r_wcnt         <= '0;
                r_sample       <= r_ones;
                r_sample_ready <= 1'b1;
                r_ones         <= '0;
            end else begin
                r_wcnt         <= r_wcnt + CW'(1);
                r_ones         <= r_ones + CW'(r_sync2);
                r_sample_ready <= 1'b0;
            end
        end
    end

    assign o_sample       = r_sample;
    assign o_sample_ready = r_sample_ready;

endmodule

// File: rtl/pdm_capture_ctrl.sv
// ---------------------------------------------------------------------------
// pdm_capture_ctrl
// Sequencer for one PDM microphone channel: gates the mic clock, waits for
// mic wake-up, feeds per-window ones counts to pdm_filter, discards the
// filter's start-up transient and holds decimated samples for the bus side.
// Ports:
//   i_clk, i_reset      clock, synchronous active-high reset
//   i_enable            level, capture requested
//   i_pdm_data          asynchronous PDM pin bit
//   i_filtered          filter output sample
//   i_filtered_ready    filter output strobe
//   o_pdm_clk_en        mic clock gate
//   o_filter_reset      filter reset
//   o_sample_ready      window strobe to the filter
//   o_sample            window ones count to the filter
//   o_running           FSM is in RUN
//   io_bus              holding register handshake (data/valid/ack/overrun)
// ---------------------------------------------------------------------------
module pdm_capture_ctrl
    import pdm_audio_pkg::*;
#(
    parameter int unsigned SAMPLE_CLKS    = SAMPLE_CLKS_DEF,
    parameter int unsigned SAMPLEHS_CLKS  = SAMPLEHS_CLKS_DEF,
    parameter int unsigned BITS           = BITS_DEF,
    parameter int unsigned WAKE_CLKS      = 1024,
    parameter int unsigned SETTLE_SAMPLES = 4,
    localparam int unsigned SW            = lg2(SAMPLEHS_CLKS - 1)
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic            i_enable,
    input  logic            i_pdm_data,
    input  logic [BITS-1:0] i_filtered,
    input  logic            i_filtered_ready,
    output logic            o_pdm_clk_en,
    output logic            o_filter_reset,
    output logic            o_sample_ready,
    output logic [SW-1:0]   o_sample,
    output logic            o_running,
    pdm_capture_ctrl_if.master io_bus
);
    localparam int unsigned WW = lg2(WAKE_CLKS - 1);
    localparam int unsigned DW = lg2(SETTLE_SAMPLES - 1);
    localparam logic [WW-1:0] LAST_WAKE    = WW'(WAKE_CLKS - 1);
    localparam logic [DW-1:0] LAST_DISCARD = DW'(SETTLE_SAMPLES - 1);

    if ((SAMPLEHS_CLKS < 3) || ((SAMPLEHS_CLKS % 2) == 0) ||
        (SAMPLE_CLKS < SAMPLEHS_CLKS) || (WAKE_CLKS == 0) || (SETTLE_SAMPLES == 0)) begin : g_bad_cfg
        $error("pdm_capture_ctrl: invalid parameter set");
    end

    state_e          r_state;
    logic [WW-1:0]   r_wake_cnt;
    logic [DW-1:0]   r_discard_cnt;
    logic [BITS-1:0] r_data;
    logic            r_data_valid;
    logic            r_overrun;
    logic            r_pdm_clk_en;
    logic            r_filter_reset;
    logic            r_running;

    logic w_win_clear;
    logic w_ovr_set;

    // Clearing on !i_enable kills a window strobe that would land on the
    // same edge the FSM drops to IDLE.
    assign w_win_clear = (r_state == StIdle) || (r_state == StWake) || !i_enable;

    assign w_ovr_set = (r_state == StRun) && i_enable && i_filtered_ready &&
                       r_data_valid && !io_bus.i_data_ack;

    pdm_window_counter #(
        .SAMPLEHS_CLKS (SAMPLEHS_CLKS)
    ) u_window (
        .i_clk          (i_clk),
        .i_reset        (i_reset),
        .i_clear        (w_win_clear),
        .i_pdm_data     (i_pdm_data),
        .o_sample       (o_sample),
        .o_sample_ready (o_sample_ready)
    );

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state        <= StIdle;
            r_wake_cnt     <= '0;
            r_discard_cnt  <= '0;
            r_data         <= '0;
            r_data_valid   <= 1'b0;
            r_overrun      <= 1'b0;
            r_pdm_clk_en   <= 1'b0;
            r_filter_reset <= 1'b1;
            r_running      <= 1'b0;
        end else begin
            // Set wins over a coincident clear.
            r_overrun <= w_ovr_set | (r_overrun & ~io_bus.i_clear_overrun);

            if (!i_enable) begin
                r_state        <= StIdle;
                r_pdm_clk_en   <= 1'b0;
                r_filter_reset <= 1'b1;
                r_running      <= 1'b0;
                r_data_valid   <= 1'b0;
            end else begin
                case (r_state)
                    StIdle: begin
                        r_state        <= StWake;
                        r_wake_cnt     <= '0;
                        r_pdm_clk_en   <= 1'b1;
                        r_filter_reset <= 1'b1;
                    end
                    StWake: begin
                        if (r_wake_cnt == LAST_WAKE) begin
                            r_state        <= StSettle;
                            r_discard_cnt  <= '0;
                            r_filter_reset <= 1'b0;
                        end else begin
                            r_wake_cnt <= r_wake_cnt + WW'(1);
                        end
                    end
                    StSettle: begin
                        // The final discarded sample is not stored either.
                        if (i_filtered_ready) begin
                            if (r_discard_cnt == LAST_DISCARD) begin
                                r_state   <= StRun;
                                r_running <= 1'b1;
                            end else begin
                                r_discard_cnt <= r_discard_cnt + DW'(1);
                            end
                        end
                    end
                    StRun: begin
                        if (i_filtered_ready) begin
                            r_data       <= i_filtered;
                            r_data_valid <= 1'b1;
                        end else if (io_bus.i_data_ack) begin
                            r_data_valid <= 1'b0;
                        end
                    end
                    default: r_state <= StIdle;
                endcase
            end
        end
    end

    assign o_pdm_clk_en        = r_pdm_clk_en;
    assign o_filter_reset      = r_filter_reset;
    assign o_running           = r_running;
    assign io_bus.o_data       = r_data;
    assign io_bus.o_data_valid = r_data_valid;
    assign io_bus.o_overrun    = r_overrun;

endmodule

// File: tb/tb_pdm_capture_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pdm_capture_ctrl
// Directed bench for pdm_capture_ctrl (WAKE_CLKS=16, SETTLE_SAMPLES=4).
// Inputs change and outputs are checked on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_pdm_capture_ctrl;
    localparam int unsigned BITS = 18;

    logic            clk;
    logic            reset;
    logic            enable;
    logic            pdm_data;
    logic [BITS-1:0] filtered;
    logic            filtered_ready;
    logic            pdm_clk_en;
    logic            filter_reset;
    logic            sample_ready;
    logic [3:0]      sample;
    logic            running;

    int total;
    int bad;

    pdm_capture_ctrl_if #(.BITS(BITS)) bus_if ();

    pdm_capture_ctrl #(
        .SAMPLE_CLKS    (375),
        .SAMPLEHS_CLKS  (15),
        .BITS           (BITS),
        .WAKE_CLKS      (16),
        .SETTLE_SAMPLES (4)
    ) dut (
        .i_clk            (clk),
        .i_reset          (reset),
        .i_enable         (enable),
        .i_pdm_data       (pdm_data),
        .i_filtered       (filtered),
        .i_filtered_ready (filtered_ready),
        .o_pdm_clk_en     (pdm_clk_en),
        .o_filter_reset   (filter_reset),
        .o_sample_ready   (sample_ready),
        .o_sample         (sample),
        .o_running        (running),
        .io_bus           (bus_if.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One-cycle filter output strobe carrying value v.
    task automatic pulse(input logic [BITS-1:0] v);
        filtered       = v;
        filtered_ready = 1'b1;
        step(1);
        filtered_ready = 1'b0;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_clk_en"}, 32'(pdm_clk_en), 32'd0);
        check({tag, "_frst"}, 32'(filter_reset), 32'd1);
        check({tag, "_valid"}, 32'(bus_if.o_data_valid), 32'd0);
        check({tag, "_running"}, 32'(running), 32'd0);
    endtask

    initial begin
        total                  = 0;
        bad                    = 0;
        reset                  = 1'b1;
        enable                 = 1'b0;
        pdm_data               = 1'b1;
        filtered               = '0;
        filtered_ready         = 1'b0;
        bus_if.i_data_ack      = 1'b0;
        bus_if.i_clear_overrun = 1'b0;
        step(3);

        // Reset state
        check_idle("rst");
        check("rst_sready", 32'(sample_ready), 32'd0);
        check("rst_sample", 32'(sample), 32'd0);
        check("rst_data", 32'(bus_if.o_data), 32'd0);
        check("rst_ovr", 32'(bus_if.o_overrun), 32'd0);
        reset = 1'b0;
        step(2);
        check_idle("idle");

        // Startup: WAKE lasts 16 cycles, filter reset falls 17 edges after enable
        enable = 1'b1;
        step(1);
        check("wake_clk_en", 32'(pdm_clk_en), 32'd1);
        check("wake_frst", 32'(filter_reset), 32'd1);
        step(15);
        check("wake_end_frst", 32'(filter_reset), 32'd1);
        step(1);
        check("settle_frst", 32'(filter_reset), 32'd0);
        check("settle_running", 32'(running), 32'd0);

        // Counting: first window strobe 15 cycles after SETTLE entry
        step(14);
        check("win_early", 32'(sample_ready), 32'd0);
        step(1);
        check("win_ones_rdy", 32'(sample_ready), 32'd1);
        check("win_ones_cnt", 32'(sample), 32'd14);
        step(1);
        check("win_strobe_1clk", 32'(sample_ready), 32'd0);
        for (int i = 0; i < 29; i++) begin
            pdm_data = ~pdm_data;
            step(1);
        end
        check("win_alt_rdy", 32'(sample_ready), 32'd1);
        check("win_alt_cnt", 32'(sample), 32'd7);
        pdm_data = 1'b0;
        step(30);
        check("win_zero_rdy", 32'(sample_ready), 32'd1);
        check("win_zero_cnt", 32'(sample), 32'd0);

        // Settle: four filter outputs discarded
        pulse(18'h00011);
        pulse(18'h00022);
        pulse(18'h00033);
        check("settle_3_running", 32'(running), 32'd0);
        pulse(18'h00044);
        check("run_running", 32'(running), 32'd1);
        check("run_valid0", 32'(bus_if.o_data_valid), 32'd0);
        check("run_data0", 32'(bus_if.o_data), 32'd0);
        pulse(18'h00123);
        check("first_valid", 32'(bus_if.o_data_valid), 32'd1);
        check("first_data", 32'(bus_if.o_data), 32'h123);
        check("first_ovr", 32'(bus_if.o_overrun), 32'd0);

        // Handshake: second sample with no ack overruns
        pulse(18'h00456);
        check("ovr_set", 32'(bus_if.o_overrun), 32'd1);
        check("ovr_data", 32'(bus_if.o_data), 32'h456);

        // Clear together with a new overrun keeps overrun set
        bus_if.i_clear_overrun = 1'b1;
        pulse(18'h00aaa);
        bus_if.i_clear_overrun = 1'b0;
        check("clr_set_ovr", 32'(bus_if.o_overrun), 32'd1);
        check("clr_set_data", 32'(bus_if.o_data), 32'haaa);
        bus_if.i_clear_overrun = 1'b1;
        step(1);
        bus_if.i_clear_overrun = 1'b0;
        check("clr_only_ovr", 32'(bus_if.o_overrun), 32'd0);
        check("clr_only_valid", 32'(bus_if.o_data_valid), 32'd1);

        // Ack coincident with ready: no overrun, valid stays
        bus_if.i_data_ack = 1'b1;
        pulse(18'h00789);
        bus_if.i_data_ack = 1'b0;
        check("ackrdy_valid", 32'(bus_if.o_data_valid), 32'd1);
        check("ackrdy_data", 32'(bus_if.o_data), 32'h789);
        check("ackrdy_ovr", 32'(bus_if.o_overrun), 32'd0);
        bus_if.i_data_ack = 1'b1;
        step(1);
        check("ack_valid", 32'(bus_if.o_data_valid), 32'd0);
        step(1);
        bus_if.i_data_ack = 1'b0;
        check("ack_idle_valid", 32'(bus_if.o_data_valid), 32'd0);
        check("ack_idle_ovr", 32'(bus_if.o_overrun), 32'd0);
        pulse(18'h0beef);
        check("refill_valid", 32'(bus_if.o_data_valid), 32'd1);
        check("refill_ovr", 32'(bus_if.o_overrun), 32'd0);

        // Abort mid-RUN; data retained
        enable = 1'b0;
        step(1);
        check_idle("abort_run");
        check("abort_run_data", 32'(bus_if.o_data), 32'hbeef);

        // Re-enable restarts the full WAKE period
        enable = 1'b1;
        step(1);
        check("re_clk_en", 32'(pdm_clk_en), 32'd1);
        step(15);
        check("re_wake_frst", 32'(filter_reset), 32'd1);
        step(1);
        check("re_settle_frst", 32'(filter_reset), 32'd0);

        // Abort mid-SETTLE on the edge a window strobe would have fired
        step(14);
        enable = 1'b0;
        step(1);
        check_idle("abort_settle");
        check("abort_settle_sready", 32'(sample_ready), 32'd0);

        // Reset during RUN with overrun set
        enable   = 1'b1;
        pdm_data = 1'b1;
        step(17);
        pulse(18'h00001);
        pulse(18'h00002);
        pulse(18'h00003);
        pulse(18'h00004);
        pulse(18'h00321);
        pulse(18'h00654);
        check("pre_rst_ovr", 32'(bus_if.o_overrun), 32'd1);
        check("pre_rst_running", 32'(running), 32'd1);
        reset = 1'b1;
        step(1);
        check_idle("mid_rst");
        check("mid_rst_ovr", 32'(bus_if.o_overrun), 32'd0);
        check("mid_rst_data", 32'(bus_if.o_data), 32'd0);
        check("mid_rst_sample", 32'(sample), 32'd0);
        check("mid_rst_sready", 32'(sample_ready), 32'd0);
        reset = 1'b0;
        step(1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
